inst_loader: RTL

Boot-time instruction loader: the transmitting end of the core's external instruction-load port (`Inst_addr_load`, `Inst_load`, `load_en`).
- Accepts a byte stream from a serial front-end (UART RX or a test driver) over a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and writes them into instruction memory at consecutive addresses.
- Holds the core in reset for the whole session and releases it once the image is complete.

---
 rtl/inst_loader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// inst_loader: boot-time loader that turns a byte stream into 32-bit instruction memory writes.
// Define INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data words.
module inst_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [31:0] Inst_addr_load,
  output logic [31:0] Inst_load,
  output logic        load_en,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef INST_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE} state_t;
  logic [7:0]  csum;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE} state_t;
`endif

  state_t      state;
  logic [23:0] part;       // lower three bytes of the count or word being assembled
  logic [1:0]  bcnt;
  logic [31:0] idx;
  logic [31:0] n_words;
  logic        fire;
  logic [31:0] assembled;

  assign fire      = byte_valid && byte_ready;
  assign assembled = {byte_data, part};

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      byte_ready     <= 1'b0;
      load_en        <= 1'b0;
      Inst_addr_load <= '0;
      Inst_load      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      cpu_rst_n      <= 1'b0;
      part           <= '0;
      bcnt           <= '0;
      idx            <= '0;
      n_words        <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      done    <= 1'b0;
      load_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_LEN;
            busy       <= 1'b1;
            cpu_rst_n  <= 1'b0;
            err        <= 1'b0;
            idx        <= '0;
            bcnt       <= '0;
            byte_ready <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end

        S_LEN: begin
          if (fire) begin
            part <= {byte_data, part[23:8]};
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              n_words <= assembled;
              if (assembled == 32'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
                state      <= S_CSUM;
`else
                state      <= S_DONE;
                byte_ready <= 1'b0;
                done       <= 1'b1;
                cpu_rst_n  <= 1'b1;
`endif
              end else if (assembled > 32'(MAX_WORDS)) begin
                state      <= S_IDLE;
                byte_ready <= 1'b0;
                busy       <= 1'b0;
                err        <= 1'b1;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (fire) begin
            part <= {byte_data, part[23:8]};
            bcnt <= bcnt + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
            if (bcnt == 2'd3) begin
              state          <= S_WRITE;
              byte_ready     <= 1'b0;
              load_en        <= 1'b1;
              Inst_addr_load <= BASE_ADDR + (idx << 2);
              Inst_load      <= assembled;
            end
          end
        end

        S_WRITE: begin
          idx <= idx + 32'd1;
          if (idx + 32'd1 < n_words) begin
            state      <= S_DATA;
            byte_ready <= 1'b1;
          end else begin
`ifdef INST_LOADER_CHECKSUM_EN
            state      <= S_CSUM;
            byte_ready <= 1'b1;
`else
            state      <= S_DONE;
            done       <= 1'b1;
            cpu_rst_n  <= 1'b1;
`endif
          end
        end

`ifdef INST_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (fire) begin
            byte_ready <= 1'b0;
            if (byte_data == csum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
        end
`endif

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
